// File: rtl/fft_32_frame_ctrl.sv
// Frame controller for an FFT_32 core: gathers 32 streamed samples, waits out the core latency,
// then streams the 32 bins. Optional macro FFT32_CTRL_FRAME_CNT_EN adds a 16-bit frame counter output.
module fft_32_frame_ctrl #(
  parameter int CORE_LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [7:0]   s_real,
  input  logic [7:0]   s_imag,
  output logic [255:0] core_xn_real,
  output logic [255:0] core_xn_imag,
  input  logic [255:0] core_xk_real,
  input  logic [255:0] core_xk_imag,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [7:0]   m_real,
  output logic [7:0]   m_imag,
  output logic [4:0]   m_index,
  output logic         m_last,
  output logic         busy
`ifdef FFT32_CTRL_FRAME_CNT_EN
  ,
  output logic [15:0]  frame_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_UNLOAD = 2'd2
  } state_t;

  state_t       state_r;
  state_t       state_nx_s;
  logic [4:0]   in_idx_r;
  logic [4:0]   out_idx_r;
  logic [3:0]   wait_cnt_r;
  logic [255:0] in_re_r;
  logic [255:0] in_im_r;
  logic [255:0] out_re_r;
  logic [255:0] out_im_r;

  logic         s_ready_s;
  logic         m_valid_s;
  logic         busy_s;
  logic [7:0]   m_real_s;
  logic [7:0]   m_imag_s;
  logic [4:0]   m_index_s;
  logic         m_last_s;
  logic [255:0] xn_re_s;
  logic [255:0] xn_im_s;
  logic         s_acc_s;
  logic         m_acc_s;
  logic         last_in_s;
  logic         last_out_s;

  assign s_acc_s    = s_valid & s_ready_s;
  assign m_acc_s    = m_valid_s & m_ready;
  assign last_in_s  = s_acc_s & (in_idx_r == 5'd31);
  assign last_out_s = m_acc_s & (out_idx_r == 5'd31);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_LOAD;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_LOAD: begin
        if (last_in_s) state_nx_s = ST_WAIT;
        else           state_nx_s = ST_LOAD;
      end
      ST_WAIT: begin
        if (wait_cnt_r == 4'd0) state_nx_s = ST_UNLOAD;
        else                    state_nx_s = ST_WAIT;
      end
      ST_UNLOAD: begin
        if (last_out_s) state_nx_s = ST_LOAD;
        else            state_nx_s = ST_UNLOAD;
      end
      default: state_nx_s = ST_LOAD;
    endcase
  end

  // Output decode; everything is forced low while reset is asserted, even before the reset edge
  always_comb begin
    s_ready_s = 1'b0;
    m_valid_s = 1'b0;
    busy_s    = 1'b0;
    m_real_s  = 8'd0;
    m_imag_s  = 8'd0;
    m_index_s = 5'd0;
    m_last_s  = 1'b0;
    xn_re_s   = 256'd0;
    xn_im_s   = 256'd0;
    if (rst_n) begin
      xn_re_s = in_re_r;
      xn_im_s = in_im_r;
      case (state_r)
        ST_LOAD: s_ready_s = 1'b1;
        ST_WAIT: busy_s = 1'b1;
        ST_UNLOAD: begin
          busy_s    = 1'b1;
          m_valid_s = 1'b1;
          m_real_s  = out_re_r[{out_idx_r, 3'b000} +: 8];
          m_imag_s  = out_im_r[{out_idx_r, 3'b000} +: 8];
          m_index_s = out_idx_r;
          m_last_s  = (out_idx_r == 5'd31);
        end
        default: s_ready_s = 1'b0;
      endcase
    end else begin
      s_ready_s = 1'b0;
    end
  end

  // Sample buffer, core capture and index/latency counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_idx_r   <= 5'd0;
      out_idx_r  <= 5'd0;
      wait_cnt_r <= 4'd0;
      in_re_r    <= 256'd0;
      in_im_r    <= 256'd0;
      out_re_r   <= 256'd0;
      out_im_r   <= 256'd0;
    end else begin
      if (s_acc_s) begin
        in_re_r[{in_idx_r, 3'b000} +: 8] <= s_real;
        in_im_r[{in_idx_r, 3'b000} +: 8] <= s_imag;
        in_idx_r <= in_idx_r + 5'd1;
      end
      if (state_r == ST_WAIT) begin
        if (wait_cnt_r == 4'd0) begin
          out_re_r <= core_xk_real;
          out_im_r <= core_xk_imag;
        end else begin
          wait_cnt_r <= wait_cnt_r - 4'd1;
        end
      end else if (last_in_s) begin
        wait_cnt_r <= 4'(CORE_LATENCY);
      end
      // 5-bit index wraps 31 -> 0 on the final bin
      if (m_acc_s) begin
        out_idx_r <= out_idx_r + 5'd1;
      end
    end
  end

`ifdef FFT32_CTRL_FRAME_CNT_EN
  logic [15:0] frame_cnt_r;

  // Completed-frame counter, wraps naturally at 16 bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_r <= 16'd0;
    end else if (last_out_s) begin
      frame_cnt_r <= frame_cnt_r + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_r;
`endif

  assign s_ready      = s_ready_s;
  assign m_valid      = m_valid_s;
  assign busy         = busy_s;
  assign m_real       = m_real_s;
  assign m_imag       = m_imag_s;
  assign m_index      = m_index_s;
  assign m_last       = m_last_s;
  assign core_xn_real = xn_re_s;
  assign core_xn_imag = xn_im_s;

endmodule

// File: doc/fft_32_frame_ctrl.md
FFT_32_FRAME_CTRL -- requirements
Module: fft_32_frame_ctrl

Interface
REQ-001 SHALL have parameter CORE_LATENCY, default 1, meaning clock edges from a core-input update to valid core output (range 0-15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port s_valid, input, 1 bit: an input sample is offered.
REQ-005 SHALL have port s_ready, output, 1 bit: the controller accepts an input sample.
REQ-006 SHALL have ports s_real and s_imag, input, 8 bits each: signed two's-complement input sample.
REQ-007 SHALL have ports core_xn_real and core_xn_imag, output, 256 bits each: packed frame to the FFT_32 core.
REQ-008 SHALL have ports core_xk_real and core_xk_imag, input, 256 bits each: packed spectrum from the FFT_32 core.
REQ-009 SHALL have port m_valid, output, 1 bit: an output bin is presented.
REQ-010 SHALL have port m_ready, input, 1 bit: the downstream accepts the output bin.
REQ-011 SHALL have ports m_real and m_imag, output, 8 bits each: output bin value.
REQ-012 SHALL have port m_index, output, 5 bits: bin number k of the presented bin.
REQ-013 SHALL have port m_last, output, 1 bit: high with bin 31.
REQ-014 SHALL have port busy, output, 1 bit: high in WAIT and UNLOAD.

Function
REQ-015 SHALL pack sample/bin n at bits [8n+7:8n] of every 256-bit vector, with n=0 at the LSB.
REQ-016 SHALL implement states LOAD, WAIT and UNLOAD, and SHALL enter LOAD from reset.
REQ-017 In LOAD, s_ready=1; each cycle with s_valid&s_ready SHALL write the sample at in_idx into the input buffer and increment in_idx.
REQ-018 Acceptance at in_idx=31 SHALL move to WAIT, wrap in_idx to 0 and load wait_cnt=CORE_LATENCY.
REQ-019 core_xn_real/imag SHALL be driven directly from the input-buffer registers; the new frame is visible from the edge that accepted sample 31.
REQ-020 In WAIT, s_ready=0 and wait_cnt SHALL decrement each cycle.
REQ-021 When wait_cnt=0 in WAIT, the controller SHALL capture core_xk_real/imag into the output buffer and enter UNLOAD.
REQ-022 Latency: with the last input accepted on edge T, m_valid SHALL first be high after edge T+1+CORE_LATENCY.
REQ-023 In UNLOAD, m_valid=1, m_real/m_imag = output buffer[out_idx], m_index=out_idx, m_last=(out_idx==31); each m_valid&m_ready SHALL increment out_idx.
REQ-024 With m_valid=1 and m_ready=0, m_real, m_imag, m_index and m_last SHALL hold stable.
REQ-025 Acceptance of bin 31 SHALL return to LOAD with out_idx=0; s_ready SHALL rise the following cycle, with no frame overlap.
REQ-026 s_valid in WAIT or UNLOAD SHALL be ignored, and the input buffer SHALL be unchanged.
REQ-027 The input buffer SHALL keep the previous frame's samples until they are overwritten.

Reset
REQ-028 With rst_n=0 at a clock edge, the controller SHALL enter LOAD, clear in_idx, out_idx and wait_cnt, and zero both buffers.
REQ-029 During reset: s_ready=0, m_valid=0, m_last=0, busy=0, m_real=m_imag=0, m_index=0, and core_xn_*=0.
REQ-030 Reset mid-frame, in any state, SHALL discard the partial frame; the first sample after reset is stored as n=0.

Configuration
REQ-031 With macro FFT32_CTRL_FRAME_CNT_EN defined, the block SHALL add output frame_cnt (16 bits, reset 0) that increments when bin 31 is accepted and wraps 0xFFFF->0x0000.
REQ-032 Without FFT32_CTRL_FRAME_CNT_EN, port frame_cnt and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 Stream 32 samples, sample0 real=0x01/imag=0xF9 through sample31 real=0x03/imag=0x0A (frame real=03F5F102...F0F301, imag=0A0F08F4...F204F9), to the real FFT_32 core -> bins out real=CE88FA16...F622AB0D, imag=52A801F2...42412BFD; bin0=0x0D/0xFD, m_last with bin31.
REQ-034 CORE_LATENCY=3, s_valid constantly high -> s_ready low for exactly 4+32 cycles after sample 31; m_valid first rises at edge T+4.
REQ-035 m_ready toggling 1,0,1,0 in UNLOAD -> each bin held while m_ready=0, no bin skipped or duplicated, m_index 0..31 in order.
REQ-036 rst_n low for one cycle after 17 accepted samples -> s_ready=0 in that cycle, busy=0; next frame's first sample lands at bits [7:0].
REQ-037 s_valid high throughout WAIT and UNLOAD with random data -> core_xn_* unchanged until the next LOAD acceptance.
REQ-038 FFT32_CTRL_FRAME_CNT_EN defined, 3 back-to-back frames -> frame_cnt 0,1,2,3 after each bin-31 acceptance; preload 0xFFFF -> wraps to 0x0000.
